booth_seq_mult: RTL

- Sequential radix-2 Booth multiplier for signed two's-complement operands.
- Sits directly upstream of the team's add/subtract stage: each cycle it issues one add, subtract or no-op of the multiplicand against a running accumulator, then arithmetic-shifts.
- Produces an exact 2*WIDTH-bit signed product with a start/done handshake.

---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_addsub.sv | 24 ++
 rtl/booth_seq_mult.sv | 116 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam int BOOTH_DEF_WIDTH = 8;
    localparam int BOOTH_CNT_W     = $clog2(BOOTH_DEF_WIDTH);

    // Counter width able to hold WIDTH-1, never narrower than one bit.
    function automatic int booth_cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Booth recoding of the pair {Q[0], q_1}.
    function automatic logic [1:0] booth_op(input logic q0, input logic q1);
        logic [1:0] op;
        case ({q0, q1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/subtract/pass stage for the Booth accumulator.
module booth_addsub
    import booth_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] m,
    input  logic [1:0]   op,
    output logic [W-1:0] result
);

    // Select acc+m, acc-m or acc; results wrap to W bits.
    always_comb begin
        result = acc;
        case (op)
            OP_ADD:  result = acc + m;
            OP_SUB:  result = acc - m;
            OP_NOP:  result = acc;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with start/done handshake.
// Optional macro BOOTH_ZERO_SKIP_EN: zero operands finish on the accepting edge.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = booth_cnt_width(WIDTH);

    state_e           state_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH:0]   m_r;
    logic [WIDTH-1:0] q_r;
    logic             q1_r;
    logic [CW-1:0]    cnt_r;

    logic [1:0]       op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   acc_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             zero_s;

    assign op_s = booth_op(q_r[0], q1_r);

    booth_addsub #(.W(WIDTH + 1)) u_addsub (
        .acc    (acc_r),
        .m      (m_r),
        .op     (op_s),
        .result (sum_s)
    );

    // Arithmetic shift right of {A,Q,q_1} after the add/sub.
    assign acc_next_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    assign q_next_s   = {sum_s[0], q_r[WIDTH-1:1]};

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_s = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
`else
    assign zero_s = 1'b0;
`endif

    // Control FSM, Booth datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {(WIDTH + 1){1'b0}};
            m_r     <= {(WIDTH + 1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            q1_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= {(2 * WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start && zero_s) begin
                        state_r <= DONE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {(2 * WIDTH){1'b0}};
                    end else if (start) begin
                        state_r <= RUN;
                        acc_r   <= {(WIDTH + 1){1'b0}};
                        m_r     <= {a[WIDTH-1], a};
                        q_r     <= b;
                        q1_r    <= 1'b0;
                        cnt_r   <= CW'(WIDTH - 1);
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    q_r   <= q_next_s;
                    q1_r  <= q_r[0];
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= DONE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {acc_next_s[WIDTH-1:0], q_next_s};
                    end else begin
                        cnt_r <= cnt_r - {{(CW - 1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
